// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream CBus port between NUM_INPUTS requesters.
// Grants in the same cycle, locks the owner until the last beat, and watches grant hold time.

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    parameter  int MAX_HOLD   = 1024,
    localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  cbus_req_t  [NUM_INPUTS-1:0]      ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]      iresps,
    output cbus_req_t                        oreq,
    input  cbus_resp_t                       oresp,
    output logic       [IDX_W-1:0]           owner,
    output logic                             busy,
    output logic                             timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;

    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              any_valid;
    logic              done;
    int                idx;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
        if (int'(cur) >= NUM_INPUTS - 1) return '0;
        return cur + IDX_W'(1);
    endfunction

    assign done    = oresp.ready && oresp.last;
    assign timeout = timeout_q;

    // Scan from the farthest offset down so the closest valid index to rr_ptr wins.
    always_comb begin
        pick      = rr_ptr_q;
        any_valid = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int off = NUM_INPUTS - 1; off >= 0; off--) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            cand = IDX_W'(idx);
            if (ireqs[cand].valid) begin
                pick      = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        oreq       = '0;
        iresps     = '0;
        owner      = '0;
        busy       = 1'b0;

        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        oreq         = ireqs[pick];
                        iresps[pick] = oresp;
                        owner        = pick;
                        busy         = 1'b1;
                        if (done) begin
                            rr_ptr_d = next_idx(pick);
                        end else begin
                            state_d    = S_LOCKED;
                            owner_d    = pick;
                            hold_cnt_d = HOLD_W'(1);
                            timeout_d  = (MAX_HOLD == 1);
                        end
                    end
                end
                S_LOCKED: begin
                    busy  = 1'b1;
                    owner = owner_q;
                    // A dropped valid without last is an abort: nothing is forwarded that cycle.
                    if (done || ireqs[owner_q].valid) begin
                        oreq            = ireqs[owner_q];
                        iresps[owner_q] = oresp;
                    end
                    if (done || !ireqs[owner_q].valid) begin
                        state_d    = S_IDLE;
                        rr_ptr_d   = next_idx(owner_q);
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        timeout_d  = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a transaction-level model.

module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int N    = 3;
    localparam int MAXH = 8;
    localparam int IW   = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    cbus_req_t  [N-1:0]     ireqs;
    cbus_resp_t [N-1:0]     iresps;
    cbus_req_t              oreq;
    cbus_resp_t             oresp;
    logic       [IW-1:0]    owner;
    logic                   busy;
    logic                   timeout;

    always #5 clk = ~clk;

    cbus_rr_arbiter #(
        .NUM_INPUTS(N),
        .MAX_HOLD  (MAXH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp),
        .owner  (owner),
        .busy   (busy),
        .timeout(timeout)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: who holds the port (-1 = nobody), where the scan starts, how long it was held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tmo   = 1'b0;

    // Snapshot of DUT outputs taken at the last checked cycle, for directed literal checks.
    cbus_req_t          s_oreq;
    cbus_resp_t [N-1:0] s_iresps;
    logic       [IW-1:0] s_owner;
    logic               s_busy;
    logic               s_tmo;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic cbus_req_t req_at(input int i);
        return ireqs[i[IW-1:0]];
    endfunction

    function automatic cbus_req_t rand_req();
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom);
        r.size     = 3'($urandom);
        r.addr     = $urandom;
        r.strobe   = 4'($urandom);
        r.data     = $urandom;
        r.len      = 8'($urandom);
        r.burst    = 2'($urandom);
        return r;
    endfunction

    // One clock: compare at the negedge against the model, advance the model, return just after posedge.
    task automatic cycle();
        cbus_req_t          e_oreq;
        cbus_resp_t [N-1:0] e_iresps;
        logic               e_busy;
        int                 e_owner;
        int                 pick;
        int                 c;
        int                 nh;
        bit                 fin;
        @(negedge clk);
        s_oreq   = oreq;
        s_iresps = iresps;
        s_owner  = owner;
        s_busy   = busy;
        s_tmo    = timeout;
        e_oreq   = '0;
        e_iresps = '0;
        e_busy   = 1'b0;
        e_owner  = 0;
        pick     = -1;
        fin      = oresp.ready && oresp.last;
        if (!reset) begin
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (pick < 0 && req_at(c).valid) pick = c;
                end
                if (pick >= 0) begin
                    e_oreq                 = req_at(pick);
                    e_iresps[pick[IW-1:0]] = oresp;
                    e_busy                 = 1'b1;
                    e_owner                = pick;
                end
            end else begin
                e_busy  = 1'b1;
                e_owner = m_owner;
                if (fin || req_at(m_owner).valid) begin
                    e_oreq                    = req_at(m_owner);
                    e_iresps[m_owner[IW-1:0]] = oresp;
                end
            end
        end
        check("oreq", 128'(oreq), 128'(e_oreq));
        check("iresps", 128'(iresps), 128'(e_iresps));
        check("busy", 128'(busy), 128'(e_busy));
        check("timeout", 128'(timeout), 128'(m_tmo));
        if (e_busy) check("owner", 128'(owner), 128'(e_owner));

        if (reset) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_tmo = 1'b0;
        end else if (m_owner < 0) begin
            m_tmo = 1'b0;
            if (pick >= 0) begin
                if (fin) m_ptr = (pick + 1) % N;
                else begin
                    m_owner = pick; m_hold = 1; m_tmo = (MAXH == 1);
                end
            end
        end else if (fin || !req_at(m_owner).valid) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_hold = 0; m_tmo = 1'b0;
        end else begin
            nh     = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
            m_tmo  = (nh == MAXH) && (m_hold != MAXH);
            m_hold = nh;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ireqs = '0;
        oresp = '0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        cycle();
        check("reset_busy", 128'(s_busy), 128'(0));
        reset = 1'b0;
    endtask

    task automatic resp(input bit rdy, input bit lst);
        oresp.ready = rdy;
        oresp.last  = lst;
        oresp.data  = $urandom;
    endtask

    int order[4];
    int n_done;
    int both_ready;
    int first_tmo;
    int n_tmo;

    initial begin
        reset = 1'b1;
        quiet();
        @(posedge clk);
        #1;
        do_reset();
        check("reset_oreq", 128'(s_oreq), 128'(0));

        // Single 1-beat request completes in the same cycle it is granted.
        ireqs[0]      = rand_req();
        ireqs[0].addr = 32'h8000_0000;
        resp(1, 1);
        cycle();
        check("single_addr", 128'(s_oreq.addr), 128'(32'h8000_0000));
        check("single_ready0", 128'(s_iresps[0].ready), 128'(1));
        check("single_iresp1", 128'(s_iresps[1]), 128'(0));
        check("single_owner", 128'(s_owner), 128'(0));
        ireqs[1] = rand_req();
        cycle();
        check("ptr_after_single", 128'(s_owner), 128'(1));

        // Pointer now at 2; requests from 0 and 2 are served 2 then 0.
        ireqs    = '0;
        ireqs[0] = rand_req();
        ireqs[2] = rand_req();
        cycle();
        check("wrap_first", 128'(s_owner), 128'(2));
        cycle();
        check("wrap_second", 128'(s_owner), 128'(0));
        ireqs[0].valid = 1'b0;
        ireqs[1]       = rand_req();
        cycle();
        check("wrap_ptr_1", 128'(s_owner), 128'(1));

        // Two requesters contend, each transaction takes two cycles.
        do_reset();
        ireqs[0]   = rand_req();
        ireqs[1]   = rand_req();
        n_done     = 0;
        both_ready = 0;
        for (int i = 0; i < 8; i++) begin
            resp(1'(i % 2), 1'(i % 2));
            cycle();
            if (s_iresps[0].ready && s_iresps[1].ready) both_ready++;
            if (i % 2 == 1 && n_done < 4) begin
                order[n_done] = int'(s_owner);
                n_done++;
            end
        end
        check("rr_order0", 128'(order[0]), 128'(0));
        check("rr_order1", 128'(order[1]), 128'(1));
        check("rr_order2", 128'(order[2]), 128'(0));
        check("rr_order3", 128'(order[3]), 128'(1));
        check("rr_both_ready", 128'(both_ready), 128'(0));

        // 4-beat burst from 0 is not preempted by 1 arriving at beat 2.
        do_reset();
        ireqs[0]     = rand_req();
        ireqs[0].len = 8'd3;
        for (int b = 1; b <= 4; b++) begin
            if (b >= 2) ireqs[1] = rand_req();
            resp(1, b == 4);
            cycle();
            check("burst_owner", 128'(s_owner), 128'(0));
            check("burst_busy", 128'(s_busy), 128'(1));
            check("burst_iresp1", 128'(s_iresps[1]), 128'(0));
        end
        resp(1, 0);
        cycle();
        check("burst_next_owner", 128'(s_owner), 128'(1));
        quiet();
        cycle();

        // Watchdog: hold the grant with ready low.
        do_reset();
        ireqs[0]  = rand_req();
        resp(0, 0);
        cycle();
        first_tmo = -1;
        n_tmo     = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (s_tmo) begin
                n_tmo++;
                if (first_tmo < 0) first_tmo = k;
            end
        end
        check("wd_first_cycle", 128'(first_tmo), 128'(8));
        check("wd_pulses", 128'(n_tmo), 128'(1));
        check("wd_still_held", 128'(s_busy), 128'(1));
        resp(1, 1);
        cycle();
        quiet();
        cycle();
        check("wd_idle_after", 128'(s_busy), 128'(0));

        // Abort: owner drops valid mid-burst.
        do_reset();
        ireqs[0] = rand_req();
        resp(1, 0);
        cycle();
        ireqs[0].valid = 1'b0;
        ireqs[1]       = rand_req();
        cycle();
        check("abort_oreq_valid", 128'(s_oreq.valid), 128'(0));
        check("abort_busy", 128'(s_busy), 128'(1));
        ireqs[0] = rand_req();
        resp(0, 0);
        cycle();
        check("abort_ptr_adv", 128'(s_owner), 128'(1));

        // Reset while locked on 1.
        reset = 1'b1;
        cycle();
        check("rst_lock_busy", 128'(s_busy), 128'(0));
        check("rst_lock_oreq", 128'(s_oreq), 128'(0));
        reset = 1'b0;
        resp(1, 1);
        cycle();
        check("rst_ptr_zero", 128'(s_owner), 128'(0));

        // Randomized traffic including aborts, bursts, watchdog expiry and resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(9) < 6) ireqs[r] = rand_req();
                else ireqs[r] = '0;
            end
            resp($urandom_range(9) < 7, $urandom_range(9) < 4);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
